spi_slave_byte_if: RTL and testbench

//  SPI slave endpoint, the far end of the SPI master link: receives sck/mosi/ss_n from an

---
 rtl/spi_slave_byte_if.sv | 152 +++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// SPI slave endpoint: oversamples the SPI pins in the clk_i domain and
// exchanges whole bytes with local logic through an rx pulse and a
// one-byte tx holding register.
module spi_slave_byte_if #(
  parameter bit         CPOL    = 1'b0,
  parameter bit         CPHA    = 1'b0,
  parameter logic [7:0] TX_IDLE = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ss_n_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  sck_sync;
  logic [1:0]  mosi_sync;
  logic [2:0]  ss_sync;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic [2:0]  bit_cnt;
  logic [7:0]  hold;
  logic        hold_full;
  logic        pending_load;
  logic        skip_shift;

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic ss_fall, ss_rise, mosi_now;
  logic accept, load_now;

  // Pin synchronisers; the extra stage on sck and ss_n provides edge detection.
  // Reset values match the idle pin levels so no false edge appears on release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sync  <= {3{CPOL}};
      mosi_sync <= 2'b00;
      ss_sync   <= 3'b111;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      ss_sync   <= {ss_sync[1:0], ss_n_i};
    end
  end

  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_sync[1] & ss_sync[2];
  assign ss_rise     = ss_sync[1] & ~ss_sync[2];
  assign mosi_now    = mosi_sync[1];

  assign accept   = tx_valid_i & ~hold_full;
  assign load_now = ~ss_rise & ((state == LOAD) |
                    ((state == SHIFT) & shift_edge & pending_load));

  // Frame state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a rising ss_n ends the frame from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = SHIFT;
      default: state_next = IDLE;
    endcase
    if (ss_rise) state_next = IDLE;
  end

  // Byte datapath: holding register, tx/rx shifters, bit counter and pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_shift      <= 8'h00;
      rx_shift      <= 8'h00;
      bit_cnt       <= 3'd0;
      hold          <= 8'h00;
      hold_full     <= 1'b0;
      pending_load  <= 1'b0;
      skip_shift    <= 1'b0;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      if (accept) begin
        hold      <= tx_data_i;
        hold_full <= 1'b1;
      end
      if (load_now) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift      <= TX_IDLE;
          tx_underrun_o <= 1'b1;
        end
        bit_cnt      <= 3'd0;
        pending_load <= 1'b0;
        skip_shift   <= (state == LOAD) & CPHA;
      end else if ((state == SHIFT) && !ss_rise) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[6:0], mosi_now};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_o    <= {rx_shift[6:0], mosi_now};
            rx_valid_o   <= 1'b1;
            pending_load <= 1'b1;
          end
        end
        if (shift_edge) begin
          if (skip_shift) skip_shift <= 1'b0;
          else            tx_shift   <= {tx_shift[6:0], 1'b0};
        end
      end
      if (ss_rise) begin
        tx_shift     <= 8'h00;
        rx_shift     <= 8'h00;
        bit_cnt      <= 3'd0;
        pending_load <= 1'b0;
        skip_shift   <= 1'b0;
      end
    end
  end

  assign miso_o     = tx_shift[7];
  assign miso_oe_o  = (state != IDLE) & ~ss_sync[1];
  assign tx_ready_o = ~hold_full;
  assign busy_o     = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: one instance in mode 0, one in mode 3, each
// driven by a bit-banged SPI master; received bytes are scoreboarded.
module tb_spi_slave_byte_if;

  localparam int HALF = 80;

  logic       clk;
  logic       rst_n;
  logic       sck       [2];
  logic       mosi      [2];
  logic       ss_n      [2];
  logic       miso      [2];
  logic       miso_oe   [2];
  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       tx_ready  [2];
  logic [7:0] rx_data   [2];
  logic       rx_valid  [2];
  logic       underrun  [2];
  logic       busy      [2];

  int checks = 0;
  int errors = 0;
  int ur_cnt [2];
  logic [7:0] rx_q0 [$];
  logic [7:0] rx_q1 [$];

  spi_slave_byte_if #(.CPOL(1'b0), .CPHA(1'b0), .TX_IDLE(8'hFF)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .sck_i(sck[0]), .mosi_i(mosi[0]), .ss_n_i(ss_n[0]),
    .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .tx_data_i(tx_data[0]),
    .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .rx_data_o(rx_data[0]),
    .rx_valid_o(rx_valid[0]), .tx_underrun_o(underrun[0]), .busy_o(busy[0]));

  spi_slave_byte_if #(.CPOL(1'b1), .CPHA(1'b1), .TX_IDLE(8'hFF)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .sck_i(sck[1]), .mosi_i(mosi[1]), .ss_n_i(ss_n[1]),
    .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .tx_data_i(tx_data[1]),
    .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .rx_data_o(rx_data[1]),
    .rx_valid_o(rx_valid[1]), .tx_underrun_o(underrun[1]), .busy_o(busy[1]));

  // System clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard monitor for the mode 0 instance.
  always @(negedge clk) begin
    logic [7:0] e0;
    if (rx_valid[0]) begin
      checks++;
      if (rx_q0.size() == 0) begin
        errors++;
        $display("[TB] FAIL rx0_unexpected got=%h required=none", rx_data[0]);
      end else begin
        e0 = rx_q0.pop_front();
        if (rx_data[0] !== e0) begin
          errors++;
          $display("[TB] FAIL rx0_data got=%h required=%h", rx_data[0], e0);
        end
      end
    end
  end

  // Scoreboard monitor for the mode 3 instance.
  always @(negedge clk) begin
    logic [7:0] e1;
    if (rx_valid[1]) begin
      checks++;
      if (rx_q1.size() == 0) begin
        errors++;
        $display("[TB] FAIL rx1_unexpected got=%h required=none", rx_data[1]);
      end else begin
        e1 = rx_q1.pop_front();
        if (rx_data[1] !== e1) begin
          errors++;
          $display("[TB] FAIL rx1_data got=%h required=%h", rx_data[1], e1);
        end
      end
    end
  end

  // Underrun pulse counters.
  initial begin
    ur_cnt[0] = 0;
    ur_cnt[1] = 0;
  end
  always @(negedge clk) begin
    if (underrun[0]) ur_cnt[0]++;
    if (underrun[1]) ur_cnt[1]++;
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Offer a byte to the holding register and wait (bounded) for acceptance.
  task automatic feedTx(input int idx, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    while (!tx_ready[idx] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[idx]) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_accept_timeout got=0 required=1");
    end
    @(posedge clk);
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  task automatic ssLow(input int idx);
    @(negedge clk);
    ss_n[idx] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ssHigh(input int idx);
    #HALF;
    ss_n[idx] = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Master side of nbits SPI bit-times; idx 0 is mode 0, idx 1 is mode 3.
  task automatic applyStimulus(input int idx, input logic [7:0] out, input int nbits,
                               output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (idx == 0) begin
        mosi[0] = out[7-i];
        #HALF;
        rd = {rd[6:0], miso[0]};
        sck[0] = 1'b1;
        #HALF;
        sck[0] = 1'b0;
      end else begin
        sck[1] = 1'b0;
        mosi[1] = out[7-i];
        #HALF;
        rd = {rd[6:0], miso[1]};
        sck[1] = 1'b1;
        #HALF;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    int ur_base;
    rst_n = 1'b0;
    sck[0] = 1'b0; sck[1] = 1'b1;
    mosi[0] = 1'b0; mosi[1] = 1'b0;
    ss_n[0] = 1'b1; ss_n[1] = 1'b1;
    tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_tx_ready", tx_ready[0], 8'h01);
    checkOutput("reset_busy", busy[0], 8'h00);
    checkOutput("reset_miso", miso[0], 8'h00);
    checkOutput("reset_miso_oe", miso_oe[0], 8'h00);
    checkOutput("reset_rx_data", rx_data[0], 8'h00);
    checkOutput("reset_rx_valid", rx_valid[0], 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 single byte.
    feedTx(0, 8'hA5);
    checkOutput("t1_hold_full", tx_ready[0], 8'h00);
    rx_q0.push_back(8'h3C);
    ssLow(0);
    checkOutput("t1_ready_after_load", tx_ready[0], 8'h01);
    checkOutput("t1_busy", busy[0], 8'h01);
    checkOutput("t1_miso_oe", miso_oe[0], 8'h01);
    applyStimulus(0, 8'h3C, 8, rd);
    checkOutput("t1_miso_byte", rd, 8'hA5);
    ssHigh(0);
    checkOutput("t1_busy_end", busy[0], 8'h00);
    checkOutput("t1_miso_oe_end", miso_oe[0], 8'h00);
    checkOutput("t1_rx_held", rx_data[0], 8'h3C);

    // Mode 3 three-byte burst with the holding register refilled on demand.
    ur_base = ur_cnt[1];
    feedTx(1, 8'hC1);
    rx_q1.push_back(8'h11);
    rx_q1.push_back(8'h22);
    rx_q1.push_back(8'h33);
    fork
      begin
        ssLow(1);
        applyStimulus(1, 8'h11, 8, rd);
        checkOutput("t2_miso_b0", rd, 8'hC1);
        applyStimulus(1, 8'h22, 8, rd);
        checkOutput("t2_miso_b1", rd, 8'hC2);
        applyStimulus(1, 8'h33, 8, rd);
        checkOutput("t2_miso_b2", rd, 8'hC3);
        ssHigh(1);
      end
      begin
        feedTx(1, 8'hC2);
        feedTx(1, 8'hC3);
      end
    join
    checkOutput("t2_underruns", 8'(ur_cnt[1] - ur_base), 8'h00);

    // Mode 3 with an empty holding register: idle byte and a single underrun.
    ur_base = ur_cnt[1];
    rx_q1.push_back(8'h5E);
    ssLow(1);
    applyStimulus(1, 8'h5E, 8, rd);
    checkOutput("t3_miso_idle", rd, 8'hFF);
    ssHigh(1);
    checkOutput("t3_underruns", 8'(ur_cnt[1] - ur_base), 8'h01);

    // Mode 0 frame aborted after 5 bits, then a clean frame.
    feedTx(0, 8'h5A);
    ssLow(0);
    applyStimulus(0, 8'hB4, 5, rd);
    ssHigh(0);
    checkOutput("t4_busy_abort", busy[0], 8'h00);
    checkOutput("t4_rx_unchanged", rx_data[0], 8'h3C);
    feedTx(0, 8'h96);
    rx_q0.push_back(8'hE7);
    ssLow(0);
    applyStimulus(0, 8'hE7, 8, rd);
    checkOutput("t4_miso_byte", rd, 8'h96);
    ssHigh(0);

    // Mode 3: byte offered exactly in the LOAD cycle goes out in the second slot.
    ur_base = ur_cnt[1];
    rx_q1.push_back(8'h12);
    rx_q1.push_back(8'h34);
    @(negedge clk);
    ss_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_busy_in_load", busy[1], 8'h00);
    checkOutput("t5_ready_in_load", tx_ready[1], 8'h01);
    tx_data[1]  = 8'hD7;
    tx_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[1] = 1'b0;
    checkOutput("t5_busy_after_load", busy[1], 8'h01);
    checkOutput("t5_hold_full", tx_ready[1], 8'h00);
    repeat (6) @(negedge clk);
    applyStimulus(1, 8'h12, 8, rd);
    checkOutput("t5_miso_b0", rd, 8'hFF);
    applyStimulus(1, 8'h34, 8, rd);
    checkOutput("t5_miso_b1", rd, 8'hD7);
    ssHigh(1);
    checkOutput("t5_underruns", 8'(ur_cnt[1] - ur_base), 8'h01);

    // Mode 0: asynchronous reset in the middle of a byte, then a normal frame.
    feedTx(0, 8'h42);
    ssLow(0);
    applyStimulus(0, 8'hF0, 3, rd);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", busy[0], 8'h00);
    checkOutput("t6_rst_miso_oe", miso_oe[0], 8'h00);
    checkOutput("t6_rst_tx_ready", tx_ready[0], 8'h01);
    checkOutput("t6_rst_rx_data", rx_data[0], 8'h00);
    checkOutput("t6_rst_miso", miso[0], 8'h00);
    checkOutput("t6_rst_underrun", underrun[0], 8'h00);
    ss_n[0] = 1'b1;
    sck[0]  = 1'b0;
    mosi[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    feedTx(0, 8'h81);
    rx_q0.push_back(8'h7E);
    ssLow(0);
    applyStimulus(0, 8'h7E, 8, rd);
    checkOutput("t6_miso_byte", rd, 8'h81);
    ssHigh(0);

    repeat (20) @(negedge clk);
    checkOutput("rx0_pending", 8'(rx_q0.size()), 8'h00);
    checkOutput("rx1_pending", 8'(rx_q1.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
